vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised single-clock video timing generator for the pixel domain. It generalises the display controller's fixed 800x480 timing with configurable porches, sync polarities and FIFO read latency. It adds pixel coordinates, frame and line strobes, and sticky FIFO-underflow detection. It consumes pixels from the read side of the pixel FIFO and drives the video_if signals HS, VS, BLANK and RGB.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch / sync / back porch (pixels)
VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch / sync / back porch (lines)
HS_POL, 0, active level of HS (0 = active-low)
VS_POL, 0, active level of VS
RD_LATENCY, 0, FIFO read-data latency; 0 = show-ahead, 1 = registered; other values illegal

Ports:
pixel_clk  in  1  pixel clock; sole clock
pixel_rst_n  in  1  asynchronous, active-low reset
enable  in  1  start request; sampled high once, the block runs until reset
fifo_empty  in  1  FIFO read-side empty
fifo_rdata  in  24  FIFO read data
fifo_read  out  1  FIFO read strobe
HS  out  1  horizontal sync
VS  out  1  vertical sync
BLANK  out  1  high during active (displayed) pixels
RGB  out  24  pixel data
x  out  clog2(HDISP)  active pixel column
y  out  clog2(VDISP)  active line
sof  out  1  start-of-frame pulse
sol  out  1  start-of-line pulse
underflow  out  1  sticky underflow flag
underflow_clr  in  1  clears underflow

Behaviour:
- Derived constants: HTOTAL=HDISP+HFP+HPULSE+HBP; VTOTAL likewise; HSTART=HFP+HPULSE+HBP; VSTART=VFP+VPULSE+VBP.
- Internal counters h (clog2(HTOTAL) bits) and v (clog2(VTOTAL) bits), both 0 at reset.
- Line order: front porch, sync, back porch, active. Frame order is the same.
- Reset (pixel_rst_n low, asynchronous) drives all outputs and pipeline registers to idle:
  - HS=~HS_POL, VS=~VS_POL.
  - BLANK, fifo_read, RGB, x, y, sof, sol, underflow = 0.
  - The running flag is cleared.
- Start: the running flag is set on the first edge where enable=1. While not running, h and v hold at 0 and outputs stay idle. enable is ignored once running.
- Counting while running:
  - h increments every cycle and wraps HTOTAL-1 -> 0.
  - On that wrap, v increments and wraps VTOTAL-1 -> 0.
- Decode from (h,v):
  - hs_act = HFP <= h < HFP+HPULSE.
  - vs_act = VFP <= v < VFP+VPULSE.
  - act = h >= HSTART and v >= VSTART.
- Stage 1 (registered decode):
  - HS=hs_act?HS_POL:~HS_POL; VS likewise.
  - BLANK=act.
  - x=act?h-HSTART:0; y=act?v-VSTART:0.
  - sol=act and h==HSTART.
  - sof=sol and v==VSTART.
- RD_LATENCY=0:
  - Timing outputs come directly from stage 1.
  - fifo_read=BLANK.
  - RGB=BLANK ? fifo_rdata : 0, combinational.
- RD_LATENCY=1:
  - fifo_read = stage-1 act.
  - HS, VS, BLANK, x, y, sof, sol come from a second register stage.
  - RGB is registered: the captured fifo_rdata when the stage-1 act bit was set, else 0.
  - fifo_read therefore leads BLANK by exactly 1 cycle.
- Latency from counter value to HS/VS/BLANK: 1+RD_LATENCY cycles.
- Underflow:
  - An underflow event is fifo_read=1 while fifo_empty=1.
  - The pixel belonging to that read outputs RGB=0.
  - The underflow flag sets on the next edge.
  - underflow_clr clears the flag. If set and clear occur in the same cycle, set wins.
  - The timing generator never stalls. fifo_read is not withheld on empty.
- Reset mid-frame: counters and the running flag are cleared. A new enable is required to restart.

Test Plan:
(Test parameters unless stated: HDISP=4, VDISP=2, HFP=1, HPULSE=2, HBP=1, VFP=1, VPULSE=1, VBP=1; giving HTOTAL=8, VTOTAL=5, 40 cycles per frame.)
1. Release reset, hold enable=0 for 50 cycles -> HS=1, VS=1, BLANK=0, fifo_read=0, RGB=0 throughout.
2. Pulse enable, RD_LATENCY=0, fifo never empty -> per 8 cycles: HS low 2 consecutive cycles, starting 1 cycle after line start. Per 40 cycles: VS low 8 cycles. BLANK high 4 cycles on each of 2 lines; 8 fifo_read strobes per frame; RGB equals fifo_rdata while BLANK.
3. Same run -> x sequences 0,1,2,3 per active line and y is 0 then 1. sol fires twice per frame, coincident with x=0. sof fires once, coincident with x=0, y=0.
4. fifo_empty=1 during the 2nd active pixel -> RGB=0 for that pixel and underflow=1 from the next cycle. Assert underflow_clr on the same cycle as a new underflow event -> underflow stays 1. Assert clr alone -> underflow goes to 0.
5. RD_LATENCY=1 -> fifo_read rises exactly 1 cycle before BLANK. RGB in each BLANK cycle equals fifo_rdata presented one cycle earlier. HS/VS are shifted by +1 cycle relative to scenario 2.
6. Assert pixel_rst_n=0 mid-active-line -> outputs go idle immediately, without waiting for a clock edge. After release, outputs stay idle until enable=1. The frame then restarts with VS timing identical to scenario 2.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Single-clock video timing generator: sync/blank/coordinate decode from free-running
// h/v counters, FIFO read strobe, optional registered read-data path, sticky underflow.
module vga_timing_gen #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned HFP        = 40,
  parameter int unsigned HPULSE     = 48,
  parameter int unsigned HBP        = 40,
  parameter int unsigned VFP        = 13,
  parameter int unsigned VPULSE     = 3,
  parameter int unsigned VBP        = 29,
  parameter int unsigned HS_POL     = 0,
  parameter int unsigned VS_POL     = 0,
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  input  logic                       enable,
  input  logic                       fifo_empty,
  input  logic [23:0]                fifo_rdata,
  output logic                       fifo_read,
  output logic                       HS,
  output logic                       VS,
  output logic                       BLANK,
  output logic [23:0]                RGB,
  output logic [$clog2(HDISP)-1:0]   x,
  output logic [$clog2(VDISP)-1:0]   y,
  output logic                       sof,
  output logic                       sol,
  output logic                       underflow,
  input  logic                       underflow_clr
);

  localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned HSTART = HFP + HPULSE + HBP;
  localparam int unsigned VSTART = VFP + VPULSE + VBP;
  localparam int unsigned XW     = $clog2(HDISP);
  localparam int unsigned YW     = $clog2(VDISP);
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] HS_BEG = HW'(HFP);
  localparam logic [HW-1:0] HS_END = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT  = HW'(HSTART);
  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(VFP);
  localparam logic [VW-1:0] VS_END = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT  = VW'(VSTART);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  localparam logic HS_ON  = 1'(HS_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = 1'(VS_POL);
  localparam logic VS_OFF = ~VS_ON;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sol;
    logic          sof;
  } tim_t;

  localparam tim_t IDLE = '{hs: HS_OFF, vs: VS_OFF, act: 1'b0, x: '0, y: '0,
                            sol: 1'b0, sof: 1'b0};

  logic          running;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  tim_t          dec_c;
  tim_t          s1;
  tim_t          out_t;
  logic          act_c;
  logic          sol_c;

  // Start latch and h/v raster counters; counters sit at 0 until started
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      running <= 1'b0;
      h       <= '0;
      v       <= '0;
    end else if (!running) begin
      running <= enable;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  // Decode sync, active window and coordinates from the current counter values
  always_comb begin
    dec_c    = IDLE;
    act_c    = (h >= H_ACT) && (v >= V_ACT);
    sol_c    = act_c && (h == H_ACT);
    dec_c.hs = ((h >= HS_BEG) && (h < HS_END)) ? HS_ON : HS_OFF;
    dec_c.vs = ((v >= VS_BEG) && (v < VS_END)) ? VS_ON : VS_OFF;
    dec_c.act = act_c;
    dec_c.sol = sol_c;
    dec_c.sof = sol_c && (v == V_ACT);
    if (act_c) begin
      dec_c.x = XW'(h - H_ACT);
      dec_c.y = YW'(v - V_ACT);
    end
  end

  // Stage 1: registered decode, forced idle until the generator is running
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      s1 <= IDLE;
    end else if (running) begin
      s1 <= dec_c;
    end else begin
      s1 <= IDLE;
    end
  end

  // The read strobe always tracks stage-1 active so pixels are requested one
  // cycle ahead of display when read data is registered.
  assign fifo_read = s1.act;

  // Any non-zero latency is treated as the registered (one-cycle) FIFO
  if (RD_LATENCY == 0) begin : g_lat0
    assign out_t = s1;
    assign RGB   = (s1.act && !fifo_empty) ? fifo_rdata : '0;
  end else begin : g_lat1
    tim_t        s2;
    logic [23:0] rgb_q;

    // Stage 2: delay timing by one cycle and capture read data alongside it
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
        s2    <= IDLE;
        rgb_q <= '0;
      end else begin
        s2    <= s1;
        rgb_q <= (s1.act && !fifo_empty) ? fifo_rdata : '0;
      end
    end

    assign out_t = s2;
    assign RGB   = rgb_q;
  end

  assign HS    = out_t.hs;
  assign VS    = out_t.vs;
  assign BLANK = out_t.act;
  assign x     = out_t.x;
  assign y     = out_t.y;
  assign sol   = out_t.sol;
  assign sof   = out_t.sof;

  // Sticky underflow: a read against an empty FIFO sets, clear loses to a set
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      underflow <= 1'b0;
    end else if (fifo_read && fifo_empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule
